// File: rtl/truco_round_judge_pkg.sv
// ============================================================================
// Module : truco_pkg
// Brief  : Shared types and constants for the truco round judge and score path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package truco_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_JUDGE    = 3'd2,
        S_REPORT   = 3'd3,
        S_HAND_END = 3'd4
    } state_t;

    localparam int DEF_CARD_W   = 3;
    localparam int WINS_W       = 2;
    localparam int SCORE_CARD_W = WINS_W;

    function automatic int pid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/truco_round_judge_if.sv
// ============================================================================
// Module : truco_round_judge_if
// Brief  : Card-offer handshake and result bundle of the round judge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface truco_round_judge_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int CARD_W      = truco_pkg::DEF_CARD_W
);
    localparam int PID_W = truco_pkg::pid_width(NUM_PLAYERS);
    localparam int WV_W  = NUM_PLAYERS * truco_pkg::WINS_W;

    logic                          New_hand;
    logic                          Man_load;
    logic [CARD_W-1:0]             Man_val;
    logic [NUM_PLAYERS-1:0]        Card_valid;
    logic [NUM_PLAYERS*CARD_W-1:0] Card;
    logic [NUM_PLAYERS-1:0]        Card_ready;
    logic [NUM_PLAYERS*CARD_W-1:0] Played;
    logic [NUM_PLAYERS-1:0]        Is_man;
    logic                          Round_done;
    logic [PID_W-1:0]              Round_winner;
    logic                          Round_tie;
    logic [WV_W-1:0]               Wins;
    logic                          Hand_end;
    logic [PID_W-1:0]              Hand_winner;
    logic                          Hand_tie;

    modport master (
        output New_hand, Man_load, Man_val, Card_valid, Card,
        input  Card_ready, Played, Is_man, Round_done, Round_winner, Round_tie,
               Wins, Hand_end, Hand_winner, Hand_tie
    );

    modport slave (
        input  New_hand, Man_load, Man_val, Card_valid, Card,
        output Card_ready, Played, Is_man, Round_done, Round_winner, Round_tie,
               Wins, Hand_end, Hand_winner, Hand_tie
    );

endinterface

`default_nettype wire

// File: rtl/truco_card_rank.sv
// ============================================================================
// Module : truco_card_rank
// Brief  : Combinational ranking: single manilha wins, else unique highest code.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module truco_card_rank #(
    parameter int NUM_PLAYERS = 2,
    parameter int CARD_W      = 3,
    parameter int PID_W       = 1
) (
    input  logic [NUM_PLAYERS*CARD_W-1:0] cards,
    input  logic [CARD_W-1:0]             man,
    input  logic                          man_en,
    output logic [PID_W-1:0]              winner,
    output logic                          tie
);
    localparam int CNT_W = $clog2(NUM_PLAYERS + 1);

    logic [CNT_W-1:0]  man_cnt;
    logic [CNT_W-1:0]  top_cnt;
    logic [PID_W-1:0]  man_idx;
    logic [PID_W-1:0]  top_idx;
    logic [CARD_W-1:0] top_code;
    logic [CARD_W-1:0] code;

    always_comb begin
        man_cnt  = '0;
        top_cnt  = '0;
        man_idx  = '0;
        top_idx  = '0;
        top_code = '0;
        code     = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            code = cards[i*CARD_W +: CARD_W];
            if (man_en && code == man) begin
                man_cnt = man_cnt + CNT_W'(1);
                man_idx = PID_W'(i);
            end
            if (i == 0 || code > top_code) begin
                top_code = code;
                top_idx  = PID_W'(i);
                top_cnt  = CNT_W'(1);
            end else if (code == top_code) begin
                top_cnt = top_cnt + CNT_W'(1);
            end
        end
        // Any manilha overrides plain code order; two or more cancel out.
        winner = (man_cnt == CNT_W'(1)) ? man_idx : top_idx;
        tie    = (man_cnt > CNT_W'(1)) || (man_cnt == '0 && top_cnt > CNT_W'(1));
    end

endmodule

`default_nettype wire

// File: rtl/truco_round_judge.sv
// ============================================================================
// Module : truco_round_judge
// Brief  : Collects one card per player, judges rounds, counts wins, ends hands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module truco_round_judge
    import truco_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int CARD_W      = DEF_CARD_W,
    parameter int ROUNDS      = 3,
    parameter int WINS_TO_END = 2
) (
    input  logic                Clk,
    input  logic                Clr,
    truco_round_judge_if.slave  bus
);
    localparam int PID_W = pid_width(NUM_PLAYERS);
    localparam int RND_W = $clog2(ROUNDS + 1);
    localparam int WV_W  = NUM_PLAYERS * WINS_W;

    state_t                        state;
    state_t                        next_state;
    logic [CARD_W-1:0]             man_code;
    logic [NUM_PLAYERS*CARD_W-1:0] played;
    logic [NUM_PLAYERS-1:0]        full;
    logic [NUM_PLAYERS-1:0]        is_man;
    logic [NUM_PLAYERS-1:0]        ready;
    logic [NUM_PLAYERS-1:0]        accept;
    logic [WV_W-1:0]               wins;
    logic [WV_W-1:0]               wins_upd;
    logic [WINS_W-1:0]             cnt;
    logic [RND_W-1:0]              rnd_cnt;
    logic [PID_W-1:0]              res_winner;
    logic [PID_W-1:0]              rank_winner;
    logic [PID_W-1:0]              hand_winner;
    logic                          res_tie;
    logic                          rank_tie;
    logic                          hand_tie;
    logic                          reach;
    logic                          last_round;

    truco_card_rank #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .CARD_W      (CARD_W),
        .PID_W       (PID_W)
    ) u_round_rank (
        .cards  (played),
        .man    (man_code),
        .man_en (1'b1),
        .winner (rank_winner),
        .tie    (rank_tie)
    );

    // Same ranker scores the hand: no manilha, highest unique win count.
    truco_card_rank #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .CARD_W      (SCORE_CARD_W),
        .PID_W       (PID_W)
    ) u_hand_rank (
        .cards  (wins),
        .man    ({SCORE_CARD_W{1'b0}}),
        .man_en (1'b0),
        .winner (hand_winner),
        .tie    (hand_tie)
    );

    assign accept     = bus.Card_valid & ready;
    assign last_round = (rnd_cnt + RND_W'(1)) == RND_W'(ROUNDS);

    always_comb begin
        wins_upd = wins;
        reach    = 1'b0;
        cnt      = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cnt = wins[i*WINS_W +: WINS_W];
            if (!res_tie && res_winner == PID_W'(i) && cnt != '1)
                cnt = cnt + WINS_W'(1);
            wins_upd[i*WINS_W +: WINS_W] = cnt;
            if (int'(cnt) >= WINS_TO_END)
                reach = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.New_hand) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (bus.Man_load) next_state = S_COLLECT;
                S_COLLECT:  if (&(full | accept)) next_state = S_JUDGE;
                S_JUDGE:    next_state = S_REPORT;
                S_REPORT:   next_state = (reach || last_round) ? S_HAND_END : S_COLLECT;
                S_HAND_END: next_state = S_HAND_END;
                default:    next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready            = '0;
        bus.Round_done   = 1'b0;
        bus.Round_winner = '0;
        bus.Round_tie    = 1'b0;
        bus.Hand_end     = 1'b0;
        bus.Hand_winner  = '0;
        bus.Hand_tie     = 1'b0;
        case (state)
            S_COLLECT: ready = ~full;
            S_REPORT: begin
                bus.Round_done   = 1'b1;
                bus.Round_winner = res_winner;
                bus.Round_tie    = res_tie;
            end
            S_HAND_END: begin
                bus.Hand_end    = 1'b1;
                bus.Hand_winner = hand_winner;
                bus.Hand_tie    = hand_tie;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            man_code   <= '0;
            played     <= '0;
            full       <= '0;
            is_man     <= '0;
            wins       <= '0;
            rnd_cnt    <= '0;
            res_winner <= '0;
            res_tie    <= 1'b0;
        end else if (bus.New_hand) begin
            // Manilha survives a new hand; it only reloads from IDLE.
            played     <= '0;
            full       <= '0;
            is_man     <= '0;
            wins       <= '0;
            rnd_cnt    <= '0;
            res_winner <= '0;
            res_tie    <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.Man_load)
                man_code <= bus.Man_val;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (accept[i]) begin
                    played[i*CARD_W +: CARD_W] <= bus.Card[i*CARD_W +: CARD_W];
                    full[i]                    <= 1'b1;
                    is_man[i]                  <= (bus.Card[i*CARD_W +: CARD_W] == man_code);
                end
            end
            if (state == S_JUDGE) begin
                res_winner <= rank_winner;
                res_tie    <= rank_tie;
            end
            if (state == S_REPORT) begin
                full    <= '0;
                rnd_cnt <= rnd_cnt + RND_W'(1);
                wins    <= wins_upd;
            end
        end
    end

    assign bus.Card_ready = ready;
    assign bus.Played     = played;
    assign bus.Is_man     = is_man;
    assign bus.Wins       = wins;

endmodule

`default_nettype wire

// File: tb/tb_truco_round_judge.sv
// ============================================================================
// Module : tb_truco_round_judge
// Brief  : Bench for truco_round_judge with 2- and 4-player instances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_truco_round_judge;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    truco_round_judge_if #(.NUM_PLAYERS(2), .CARD_W(3)) b2 ();
    truco_round_judge_if #(.NUM_PLAYERS(4), .CARD_W(3)) b4 ();

    truco_round_judge #(.NUM_PLAYERS(2), .CARD_W(3), .ROUNDS(3), .WINS_TO_END(2))
        dut2 (.Clk(clk), .Clr(clr), .bus(b2));
    truco_round_judge #(.NUM_PLAYERS(4), .CARD_W(3), .ROUNDS(3), .WINS_TO_END(2))
        dut4 (.Clk(clk), .Clr(clr), .bus(b4));

    typedef struct {
        int w; bit tie; int lat; int wins; bit he; int hw; bit ht; int im; int played;
    } res_t;

    // ---------------- reference model ----------------
    function automatic void ref_judge(input int n, input int c[4], input int man,
                                      output int w, output bit t);
        int mans[$];
        int tops[$];
        int mx = -1;
        for (int i = 0; i < n; i++) if (c[i] == man) mans.push_back(i);
        for (int i = 0; i < n; i++) if (c[i] > mx) mx = c[i];
        for (int i = 0; i < n; i++) if (c[i] == mx) tops.push_back(i);
        if (mans.size() == 1) begin w = mans[0]; t = 1'b0; end
        else if (mans.size() > 1) begin w = 0; t = 1'b1; end
        else begin w = tops[0]; t = (tops.size() != 1); end
    endfunction

    function automatic void ref_hand(input int n, input int wn[4], output int w, output bit t);
        int tops[$];
        int mx = -1;
        for (int i = 0; i < n; i++) if (wn[i] > mx) mx = wn[i];
        for (int i = 0; i < n; i++) if (wn[i] == mx) tops.push_back(i);
        w = tops[0];
        t = (tops.size() != 1);
    endfunction

    // ---------------- drivers ----------------
    task automatic start2(input int man);
        @(negedge clk); b2.New_hand = 1'b1;
        @(negedge clk); b2.New_hand = 1'b0; b2.Man_load = 1'b1; b2.Man_val = 3'(man);
        @(negedge clk); b2.Man_load = 1'b0;
    endtask

    task automatic start4(input int man);
        @(negedge clk); b4.New_hand = 1'b1;
        @(negedge clk); b4.New_hand = 1'b0; b4.Man_load = 1'b1; b4.Man_val = 3'(man);
        @(negedge clk); b4.Man_load = 1'b0;
    endtask

    task automatic round2(input int c0, input int c1, output res_t r);
        @(negedge clk); b2.Card = {3'(c1), 3'(c0)}; b2.Card_valid = 2'b11;
        @(negedge clk); b2.Card_valid = 2'b00;
        r.im = int'(b2.Is_man); r.played = int'(b2.Played); r.lat = 1;
        while (b2.Round_done !== 1'b1 && r.lat < 8) begin @(negedge clk); r.lat++; end
        r.w = int'(b2.Round_winner); r.tie = b2.Round_tie;
        @(negedge clk);
        r.wins = int'(b2.Wins); r.he = b2.Hand_end; r.hw = int'(b2.Hand_winner); r.ht = b2.Hand_tie;
    endtask

    task automatic round4(input int c[4], output res_t r);
        @(negedge clk); b4.Card = {3'(c[3]), 3'(c[2]), 3'(c[1]), 3'(c[0])}; b4.Card_valid = 4'hF;
        @(negedge clk); b4.Card_valid = 4'h0;
        r.im = int'(b4.Is_man); r.played = int'(b4.Played); r.lat = 1;
        while (b4.Round_done !== 1'b1 && r.lat < 8) begin @(negedge clk); r.lat++; end
        r.w = int'(b4.Round_winner); r.tie = b4.Round_tie;
        @(negedge clk);
        r.wins = int'(b4.Wins); r.he = b4.Hand_end; r.hw = int'(b4.Hand_winner); r.ht = b4.Hand_tie;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b0;
        repeat (2) @(negedge clk);
        nchk++; if ({b2.Card_ready, b2.Played, b2.Is_man, b2.Wins} !== 14'd0) begin nerr++;
            $display("FAIL reset_dut2 got=%h want=0", {b2.Card_ready, b2.Played, b2.Is_man, b2.Wins}); end
        nchk++; if ({b2.Hand_end, b2.Round_done, b2.Hand_tie, b2.Round_tie} !== 4'd0) begin nerr++;
            $display("FAIL reset_flags got=%b want=0000", {b2.Hand_end, b2.Round_done, b2.Hand_tie, b2.Round_tie}); end
        nchk++; if ({b4.Card_ready, b4.Wins, b4.Played} !== 24'd0) begin nerr++;
            $display("FAIL reset_dut4 got=%h want=0", {b4.Card_ready, b4.Wins, b4.Played}); end
        clr = 1'b1;
        @(negedge clk); b2.Card = 6'o77; b2.Card_valid = 2'b11;
        @(negedge clk); b2.Card_valid = 2'b00;
        nchk++; if (b2.Card_ready !== 2'b00 || b2.Played !== 6'd0) begin nerr++;
            $display("FAIL idle_ignores_cards ready=%b played=%h want 0/0", b2.Card_ready, b2.Played); end
    endtask

    task automatic test_manilha_round();
        res_t r;
        start2(5);
        round2(5, 7, r);
        nchk++; if (r.im !== 1) begin nerr++; $display("FAIL man_is_man got=%0d want=1", r.im); end
        nchk++; if (r.lat !== 2) begin nerr++; $display("FAIL man_latency got=%0d want=2", r.lat); end
        nchk++; if (r.w !== 0 || r.tie !== 1'b0) begin nerr++;
            $display("FAIL man_winner got=%0d tie=%0b want=0 tie=0", r.w, r.tie); end
        nchk++; if (r.wins !== 1 || r.he !== 1'b0) begin nerr++;
            $display("FAIL man_wins got=%0d he=%0b want=1 he=0", r.wins, r.he); end
    endtask

    task automatic test_high_card();
        int ca[3] = '{3, 4, 1};
        int cb[3] = '{6, 2, 6};
        int ew[3] = '{1, 0, 1};
        int ewins[3] = '{4, 5, 9};
        res_t r;
        start2(5);
        for (int k = 0; k < 3; k++) begin
            round2(ca[k], cb[k], r);
            nchk++; if (r.w !== ew[k] || r.tie !== 1'b0) begin nerr++;
                $display("FAIL high_winner r%0d got=%0d tie=%0b want=%0d", k, r.w, r.tie, ew[k]); end
            nchk++; if (r.wins !== ewins[k] || r.he !== (k == 2)) begin nerr++;
                $display("FAIL high_wins r%0d got=%0d he=%0b want=%0d", k, r.wins, r.he, ewins[k]); end
        end
        nchk++; if (r.hw !== 1 || r.ht !== 1'b0) begin nerr++;
            $display("FAIL high_hand got=%0d tie=%0b want=1 tie=0", r.hw, r.ht); end
        nchk++; if (b2.Card_ready !== 2'b00 || b2.Hand_end !== 1'b1) begin nerr++;
            $display("FAIL hand_end_hold ready=%b he=%b want 00/1", b2.Card_ready, b2.Hand_end); end
    endtask

    task automatic test_ties();
        res_t r;
        start2(0);
        for (int k = 0; k < 3; k++) begin
            round2(4, 4, r);
            nchk++; if (r.tie !== 1'b1 || r.wins !== 0 || r.he !== (k == 2)) begin nerr++;
                $display("FAIL tie_round r%0d tie=%0b wins=%0d he=%0b want 1/0/%0d", k, r.tie, r.wins, r.he, k == 2); end
        end
        nchk++; if (r.ht !== 1'b1) begin nerr++; $display("FAIL tie_hand got=%0b want=1", r.ht); end
    endtask

    task automatic test_four_player();
        int dones = 0;
        int lat = 0;
        start4(0);
        @(negedge clk); b4.Card = {3'd0, 3'd6, 3'd0, 3'd0}; b4.Card_valid = 4'b0100;
        @(negedge clk); b4.Card = {3'd0, 3'd1, 3'd0, 3'd3}; b4.Card_valid = 4'b0101;
        @(negedge clk); b4.Card = {3'd0, 3'd7, 3'd2, 3'd4}; b4.Card_valid = 4'b0111;
        @(negedge clk);
        nchk++; if (b4.Card_ready !== 4'b1000) begin nerr++;
            $display("FAIL p4_ready got=%b want=1000", b4.Card_ready); end
        b4.Card = {3'd5, 3'd0, 3'd0, 3'd0}; b4.Card_valid = 4'b1000;
        @(negedge clk); b4.Card_valid = 4'b0000;
        nchk++; if (b4.Played !== {3'd5, 3'd6, 3'd2, 3'd3}) begin nerr++;
            $display("FAIL p4_played got=%o want=5623", b4.Played); end
        for (int k = 1; k <= 6; k++) begin
            if (b4.Round_done === 1'b1) begin
                dones++; lat = k;
                nchk++; if (b4.Round_winner !== 2'd2 || b4.Round_tie !== 1'b0) begin nerr++;
                    $display("FAIL p4_winner got=%0d tie=%0b want=2", b4.Round_winner, b4.Round_tie); end
            end
            @(negedge clk);
        end
        nchk++; if (dones !== 1 || lat !== 2) begin nerr++;
            $display("FAIL p4_judged_once count=%0d lat=%0d want 1/2", dones, lat); end
    endtask

    task automatic test_two_manilhas();
        int c[4] = '{5, 7, 5, 6};
        res_t r;
        start4(5);
        round4(c, r);
        nchk++; if (r.im !== 5) begin nerr++; $display("FAIL two_man_is_man got=%0d want=5", r.im); end
        nchk++; if (r.tie !== 1'b1 || r.wins !== 0) begin nerr++;
            $display("FAIL two_man got tie=%0b wins=%0d want 1/0", r.tie, r.wins); end
    endtask

    task automatic test_random();
        int c[4];
        int wn[4];
        int man, ew, ehw, ewins, eim, rounds;
        bit et, ehe, eht;
        res_t r;
        for (int h = 0; h < 6; h++) begin
            man = $urandom_range(0, 7);
            wn = '{0, 0, 0, 0};
            rounds = 0;
            ehe = 1'b0;
            start4(man);
            for (int rd = 0; rd < 3 && !ehe; rd++) begin
                eim = 0;
                for (int i = 0; i < 4; i++) begin
                    c[i] = $urandom_range(0, 7);
                    if (c[i] == man) eim += (1 << i);
                end
                ref_judge(4, c, man, ew, et);
                if (!et && wn[ew] < 3) wn[ew]++;
                rounds++;
                ewins = 0;
                ehe = (rounds == 3);
                for (int i = 0; i < 4; i++) begin
                    ewins += wn[i] << (2 * i);
                    if (wn[i] >= 2) ehe = 1'b1;
                end
                round4(c, r);
                nchk++; if (r.tie !== et || (!et && r.w !== ew) || r.im !== eim) begin nerr++;
                    $display("FAIL rand_round h%0d r%0d got w=%0d t=%0b im=%0d want w=%0d t=%0b im=%0d",
                             h, rd, r.w, r.tie, r.im, ew, et, eim); end
                nchk++; if (r.wins !== ewins || r.he !== ehe || r.lat !== 2) begin nerr++;
                    $display("FAIL rand_wins h%0d r%0d got=%0d he=%0b lat=%0d want=%0d he=%0b lat=2",
                             h, rd, r.wins, r.he, r.lat, ewins, ehe); end
            end
            ref_hand(4, wn, ehw, eht);
            nchk++; if (r.ht !== eht || (!eht && r.hw !== ehw)) begin nerr++;
                $display("FAIL rand_hand h%0d got w=%0d t=%0b want w=%0d t=%0b", h, r.hw, r.ht, ehw, eht); end
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        start2(5);
        @(negedge clk); b2.Card = {3'd0, 3'd3}; b2.Card_valid = 2'b01;
        @(negedge clk); b2.Card_valid = 2'b00;
        nchk++; if (b2.Card_ready !== 2'b10 || b2.Played !== {3'd0, 3'd3}) begin nerr++;
            $display("FAIL partial ready=%b played=%o want 10/03", b2.Card_ready, b2.Played); end
        #2 clr = 1'b0;
        #1;
        nchk++; if ({b2.Card_ready, b2.Played, b2.Is_man, b2.Wins} !== 14'd0) begin nerr++;
            $display("FAIL async_clr got=%h want=0", {b2.Card_ready, b2.Played, b2.Is_man, b2.Wins}); end
        @(negedge clk); clr = 1'b1;
        @(negedge clk); b2.Man_load = 1'b1; b2.Man_val = 3'd5;
        @(negedge clk); b2.Man_load = 1'b0;
        nchk++; if (b2.Card_ready !== 2'b11 || b2.Played !== 6'd0) begin nerr++;
            $display("FAIL after_clr ready=%b played=%o want 11/00", b2.Card_ready, b2.Played); end
        b2.Card = {3'd0, 3'd2}; b2.Card_valid = 2'b01;
        @(negedge clk); b2.Card = {3'd6, 3'd0}; b2.Card_valid = 2'b10; b2.New_hand = 1'b1;
        @(negedge clk); b2.Card_valid = 2'b00; b2.New_hand = 1'b0;
        nchk++; if (b2.Card_ready !== 2'b00 || b2.Played !== 6'd0 || b2.Is_man !== 2'b00) begin nerr++;
            $display("FAIL new_hand_wins ready=%b played=%o is_man=%b want 00/00/00", b2.Card_ready, b2.Played, b2.Is_man); end
        for (int k = 0; k < 5; k++) begin
            if (b2.Round_done !== 1'b0 || b2.Hand_end !== 1'b0) dones++;
            @(negedge clk);
        end
        nchk++; if (dones !== 0) begin nerr++; $display("FAIL dropped_card_judged got=%0d want=0", dones); end
    endtask

    initial begin
        b2.New_hand = 1'b0; b2.Man_load = 1'b0; b2.Man_val = '0; b2.Card_valid = '0; b2.Card = '0;
        b4.New_hand = 1'b0; b4.Man_load = 1'b0; b4.Man_val = '0; b4.Card_valid = '0; b4.Card = '0;
        test_reset();
        test_manilha_round();
        test_high_card();
        test_ties();
        test_four_player();
        test_two_manilhas();
        test_random();
        test_abort();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
